// File: rtl/hist_pkg.sv
// ---------------------------------------------------------------------------
// hist_pkg
// Shared definitions for the histogram readout block: frame header bytes,
// ADC code width (one histogram bin per ADC code), SRAM address width and
// the readout FSM state encoding.
// ---------------------------------------------------------------------------
package hist_pkg;

    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;
    localparam int         ADC_WIDTH = 12;
    localparam int         SRAM_AW   = 21;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        HDR0,
        HDR1,
        RD_STROBE,
        RD_LATCH,
        SEND,
        CLR_STROBE,
        NEXT,
        CSUM,
        FIN
    } state_t;

endpackage

// File: rtl/sram_port.sv
// ---------------------------------------------------------------------------
// sram_port
// Pad-side timing for an asynchronous byte-wide SRAM. The controlling FSM
// says which access it is in now (i_*_cur) and which it will be in next
// cycle (i_*_nxt); the strobes are registered from the next-cycle view so
// they line up exactly with the FSM state and never glitch.
//
//   Read  : CE=OE=0, WE=1 for SRAM_WAIT cycles, bus hi-Z; data captured on
//           the last strobe cycle while OE is still low.
//   Write : SRAM_WAIT+2 cycles with the bus driven throughout and OE=1; CE/WE
//           are low only in the middle SRAM_WAIT cycles, giving one cycle of
//           address/data setup before and hold after the write pulse.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rd_cur / i_rd_nxt       FSM in read strobe state now / next cycle
//   i_wr_cur / i_wr_nxt       FSM in write strobe state now / next cycle
//   i_wdata                   byte to drive during writes
//   o_last                    current cycle is the final cycle of the access
//   o_rd_data                 byte captured by the last read
//   io_sram_data              bidirectional SRAM data bus
//   o_sram_ce_n/we_n/oe_n     active-low SRAM strobes
// ---------------------------------------------------------------------------
module sram_port
    import hist_pkg::*;
#(
    parameter int SRAM_WAIT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rd_cur,
    input  logic       i_rd_nxt,
    input  logic       i_wr_cur,
    input  logic       i_wr_nxt,
    input  logic [7:0] i_wdata,
    output logic       o_last,
    output logic [7:0] o_rd_data,
    inout  wire  [7:0] io_sram_data,
    output logic       o_sram_ce_n,
    output logic       o_sram_we_n,
    output logic       o_sram_oe_n
);

    localparam int CW = $clog2(SRAM_WAIT + 2);

    logic [CW-1:0] r_cnt;
    logic          r_ce_n;
    logic          r_we_n;
    logic          r_oe_n;
    logic          r_drive;
    logic [7:0]    r_rd_data;

    logic [CW-1:0] w_cnt_nxt;
    logic          w_we_win;

    // The count restarts whenever an access begins; it only advances while
    // the FSM stays in the same access.
    assign w_cnt_nxt = ((i_rd_cur && i_rd_nxt) || (i_wr_cur && i_wr_nxt))
                       ? r_cnt + 1'b1 : '0;

    // Write pulse sits between the setup cycle (count 0) and the hold
    // cycle (count SRAM_WAIT+1).
    assign w_we_win = i_wr_nxt && (w_cnt_nxt != '0)
                      && (w_cnt_nxt <= CW'(SRAM_WAIT));

    assign o_last = i_rd_cur ? (r_cnt == CW'(SRAM_WAIT - 1))
                             : (i_wr_cur && (r_cnt == CW'(SRAM_WAIT + 1)));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_ce_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_drive   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_oe_n  <= ~i_rd_nxt;
            r_ce_n  <= ~(i_rd_nxt || w_we_win);
            r_we_n  <= ~w_we_win;
            r_drive <= i_wr_nxt;
            if (i_rd_cur && o_last) begin
                r_rd_data <= io_sram_data;
            end
        end
    end

    // The bus is only driven in write accesses, where OE is held high.
    assign io_sram_data = r_drive ? i_wdata : 8'bz;

    assign o_rd_data   = r_rd_data;
    assign o_sram_ce_n = r_ce_n;
    assign o_sram_we_n = r_we_n;
    assign o_sram_oe_n = r_oe_n;

endmodule

// File: rtl/histogram_readout.sv
// ---------------------------------------------------------------------------
// histogram_readout
// Streams a histogram held in external SRAM as a byte frame:
//   A5 5A, N_BINS*BYTES_PER_BIN data bytes from BASE_ADDR upwards, checksum
// (mod-256 sum of the data bytes). Optionally zeroes each byte in SRAM right
// after it has been sent, so the histogram is ready for the next run.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 one-cycle pulse, begins a readout (ignored if busy)
//   i_clear_after_read      sampled at start; zero each byte after sending
//   o_busy                  high from accepted start until done
//   o_done                  one-cycle pulse at end of frame
//   o_sram_req / i_sram_gnt SRAM bus request / grant from the arbiter
//   io_sram_data            SRAM data bus
//   o_sram_ce_n/we_n/oe_n   active-low SRAM strobes
//   o_sram_a                SRAM byte address
//   o_tx_data/o_tx_valid    output byte stream, i_tx_ready backpressure
// ---------------------------------------------------------------------------
module histogram_readout
    import hist_pkg::*;
#(
    parameter int                 N_BINS        = 1 << ADC_WIDTH,
    parameter int                 BYTES_PER_BIN = 4,
    parameter logic [SRAM_AW-1:0] BASE_ADDR     = '0,
    parameter int                 SRAM_WAIT     = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_clear_after_read,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_sram_req,
    input  logic               i_sram_gnt,
    inout  wire  [7:0]         io_sram_data,
    output logic               o_sram_ce_n,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n,
    output logic [SRAM_AW-1:0] o_sram_a,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready
);

    localparam int                 TOTAL     = N_BINS * BYTES_PER_BIN;
    localparam logic [SRAM_AW-1:0] LAST_ADDR = BASE_ADDR + SRAM_AW'(TOTAL - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_busy;
    logic               r_done;
    logic               r_sram_req;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic [SRAM_AW-1:0] r_addr;
    logic [7:0]         r_csum;
    logic               r_clear;

    logic               w_xfer;
    logic               w_last_byte;
    logic               w_acc_last;
    logic [7:0]         w_rd_data;

    assign w_xfer      = r_tx_valid && i_tx_ready;
    assign w_last_byte = (r_addr == LAST_ADDR);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment first means every path assigns
    // w_state_nxt, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:       if (i_start)    w_state_nxt = REQ;
            REQ:        if (i_sram_gnt) w_state_nxt = HDR0;
            HDR0:       if (w_xfer)     w_state_nxt = HDR1;
            HDR1:       if (w_xfer)     w_state_nxt = RD_STROBE;
            RD_STROBE:  if (w_acc_last) w_state_nxt = RD_LATCH;
            RD_LATCH:                   w_state_nxt = SEND;
            SEND:       if (w_xfer)     w_state_nxt = r_clear ? CLR_STROBE : NEXT;
            CLR_STROBE: if (w_acc_last) w_state_nxt = NEXT;
            NEXT:                       w_state_nxt = w_last_byte ? CSUM : RD_STROBE;
            CSUM:       if (w_xfer)     w_state_nxt = FIN;
            FIN:                        w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath and registered outputs ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sram_req <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_addr     <= '0;
            r_csum     <= '0;
            r_clear    <= 1'b0;
        end else begin
            // Status outputs follow the state being entered so they line up
            // with it; the bus request is released on entry to FIN.
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= (w_state_nxt == FIN);
            r_sram_req <= (w_state_nxt != IDLE) && (w_state_nxt != FIN);

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_csum  <= '0;
                        r_addr  <= BASE_ADDR;
                        r_clear <= i_clear_after_read;
                    end
                end
                REQ: begin
                    if (i_sram_gnt) begin
                        r_tx_data  <= HDR_BYTE0;
                        r_tx_valid <= 1'b1;
                    end
                end
                HDR0: begin
                    if (w_xfer) begin
                        r_tx_data <= HDR_BYTE1;
                    end
                end
                HDR1, SEND, CSUM: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                    end
                end
                RD_LATCH: begin
                    r_tx_data  <= w_rd_data;
                    r_tx_valid <= 1'b1;
                    r_csum     <= r_csum + w_rd_data;
                end
                NEXT: begin
                    r_addr <= r_addr + 1'b1;
                    if (w_last_byte) begin
                        r_tx_data  <= r_csum;
                        r_tx_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- SRAM pad control ----------------
    sram_port #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_sram_port (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rd_cur     (r_state == RD_STROBE),
        .i_rd_nxt     (w_state_nxt == RD_STROBE),
        .i_wr_cur     (r_state == CLR_STROBE),
        .i_wr_nxt     (w_state_nxt == CLR_STROBE),
        .i_wdata      (8'h00),
        .o_last       (w_acc_last),
        .o_rd_data    (w_rd_data),
        .io_sram_data (io_sram_data),
        .o_sram_ce_n  (o_sram_ce_n),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_oe_n  (o_sram_oe_n)
    );

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sram_req = r_sram_req;
    assign o_sram_a   = r_addr;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;

endmodule

// File: tb/tb_histogram_readout.sv
// ---------------------------------------------------------------------------
// tb_histogram_readout
// Directed bench: 4 bins x 4 bytes, SRAM_WAIT=2, behavioural SRAM and bus
// arbiter, byte collector on the stream output.
// ---------------------------------------------------------------------------
module tb_histogram_readout;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear_after_read;
    logic        busy;
    logic        done;
    logic        sram_req;
    logic        sram_gnt;
    wire  [7:0]  sram_io;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [20:0] sram_a;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    histogram_readout #(
        .N_BINS        (4),
        .BYTES_PER_BIN (4),
        .BASE_ADDR     (21'h0),
        .SRAM_WAIT     (2)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_clear_after_read (clear_after_read),
        .o_busy             (busy),
        .o_done             (done),
        .o_sram_req         (sram_req),
        .i_sram_gnt         (sram_gnt),
        .io_sram_data       (sram_io),
        .o_sram_ce_n        (sram_ce_n),
        .o_sram_we_n        (sram_we_n),
        .o_sram_oe_n        (sram_oe_n),
        .o_sram_a           (sram_a),
        .o_tx_data          (tx_data),
        .o_tx_valid         (tx_valid),
        .i_tx_ready         (tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [7:0] mem [16];
    logic [1:0] fill_cmd;

    assign sram_io = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[3:0]] : 8'bz;

    always @(posedge clk) begin
        if (fill_cmd == 2'd1) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 1);
        end else if (fill_cmd == 2'd2) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_a[3:0]] <= sram_io;
        end
    end

    // ---------------- arbiter and sink ----------------
    int gnt_delay;
    int gnt_wait;
    bit rand_ready;

    initial begin
        sram_gnt = 1'b0;
        gnt_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!sram_req) begin
                sram_gnt = 1'b0;
                gnt_wait = 0;
            end else if (gnt_wait >= gnt_delay) begin
                sram_gnt = 1'b1;
            end else begin
                gnt_wait++;
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] rx_q [$];
    int   done_cnt   = 0;
    int   rd_cnt     = 0;
    int   wr_cnt     = 0;
    int   stall_err  = 0;
    int   pregnt_err = 0;
    int   bus_err    = 0;
    int   addr_err   = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic prev_oe = 1'b1;
    logic prev_we = 1'b1;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (done) done_cnt++;
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (!sram_gnt && (tx_valid || !sram_ce_n || !sram_oe_n || !sram_we_n)) pregnt_err++;
        if (!sram_oe_n && !sram_we_n) bus_err++;
        if ((!sram_ce_n || !sram_oe_n || !sram_we_n) && sram_a > 21'd15) addr_err++;
        if (sram_oe_n && !prev_oe) rd_cnt++;
        if (sram_we_n && !prev_we) wr_cnt++;
        prev_oe = sram_oe_n;
        prev_we = sram_we_n;
    end

    // ---------------- helpers ----------------
    int base_rx, base_done, base_rd, base_wr;

    task automatic fill(input logic [1:0] kind);
        @(negedge clk);
        fill_cmd = kind;
        @(negedge clk);
        fill_cmd = 2'd0;
    endtask

    task automatic snap();
        base_rx   = rx_q.size();
        base_done = done_cnt;
        base_rd   = rd_cnt;
        base_wr   = wr_cnt;
    endtask

    task automatic start_frame(input logic clr);
        @(negedge clk);
        clear_after_read = clr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_after_read = 1'b0;
    endtask

    // kind: 0 = bytes 01..10, 1 = all 00, 2 = all FF
    task automatic finish_check(input string tag, input int exp_wr, input int kind,
                                input logic [7:0] csum);
        bit   ok;
        int   n;
        logic [7:0] e;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_once"}, 32'(done_cnt - base_done), 32'd1);
        check({tag, "_reads"}, 32'(rd_cnt - base_rd), 32'd16);
        check({tag, "_writes"}, 32'(wr_cnt - base_wr), 32'(exp_wr));
        n = rx_q.size() - base_rx;
        check({tag, "_len"}, 32'(n), 32'd19);
        if (n >= 19) begin
            check({tag, "_h0"}, 32'(rx_q[base_rx]), 32'h A5);
            check({tag, "_h1"}, 32'(rx_q[base_rx + 1]), 32'h5A);
            for (int i = 0; i < 16; i++) begin
                e = (kind == 0) ? 8'(i + 1) : (kind == 1) ? 8'h00 : 8'hFF;
                check($sformatf("%s_d%0d", tag, i), 32'(rx_q[base_rx + 2 + i]), 32'(e));
            end
            check({tag, "_csum"}, 32'(rx_q[base_rx + 18]), 32'(csum));
        end
    endtask

    // ---------------- main sequence ----------------
    int nz;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_after_read = 1'b0;
        fill_cmd = 2'd0;
        rand_ready = 0;
        gnt_delay = 0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(sram_req), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'b111);
        rst = 1'b0;

        // A: incrementing pattern, sink always ready
        fill(2'd1);
        snap();
        start_frame(1'b0);
        finish_check("a", 0, 0, 8'h88);

        // B: random backpressure, same stream
        rand_ready = 1;
        snap();
        start_frame(1'b0);
        finish_check("b", 0, 0, 8'h88);
        rand_ready = 0;
        repeat (2) @(negedge clk);

        // C: clear after read, then a readout of the cleared histogram
        snap();
        start_frame(1'b1);
        finish_check("c", 16, 0, 8'h88);
        nz = 0;
        for (int i = 0; i < 16; i++) if (mem[i] != 8'h00) nz++;
        check("c_mem_zero", 32'(nz), 32'd0);
        snap();
        start_frame(1'b0);
        finish_check("c2", 0, 1, 8'h00);

        // D: grant withheld 50 cycles
        fill(2'd1);
        gnt_delay = 50;
        snap();
        start_frame(1'b0);
        repeat (40) @(negedge clk);
        check("d_wait_valid", 32'(tx_valid), 32'd0);
        check("d_wait_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'b111);
        check("d_wait_req", 32'(sram_req), 32'd1);
        check("d_wait_busy", 32'(busy), 32'd1);
        check("d_wait_rx", 32'(rx_q.size() - base_rx), 32'd0);
        finish_check("d", 0, 0, 8'h88);
        gnt_delay = 0;

        // E: reset mid-frame, then a full frame
        snap();
        start_frame(1'b0);
        for (int i = 0; i < 2000 && (rx_q.size() - base_rx) < 7; i++) @(negedge clk);
        check("e_reached_b7", 32'((rx_q.size() - base_rx) >= 7), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("e_rst_busy", 32'(busy), 32'd0);
        check("e_rst_valid", 32'(tx_valid), 32'd0);
        check("e_rst_data", 32'(tx_data), 32'd0);
        check("e_rst_req", 32'(sram_req), 32'd0);
        check("e_rst_done", 32'(done), 32'd0);
        check("e_rst_addr", 32'(sram_a), 32'd0);
        check("e_rst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'b111);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        snap();
        start_frame(1'b0);
        finish_check("e", 0, 0, 8'h88);

        // F: all FF, extra start pulse while busy
        fill(2'd2);
        snap();
        start_frame(1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_check("f", 0, 2, 8'hF0);
        repeat (30) @(negedge clk);
        check("f_busy_stays_low", 32'(busy), 32'd0);
        check("f_no_second_frame", 32'(rx_q.size() - base_rx), 32'd19);
        check("f_done_total", 32'(done_cnt - base_done), 32'd1);

        // protocol watchers over the whole run
        check("stall_hold", 32'(stall_err), 32'd0);
        check("no_access_before_grant", 32'(pregnt_err), 32'd0);
        check("no_oe_we_overlap", 32'(bus_err), 32'd0);
        check("addr_in_range", 32'(addr_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
